// File: rtl/i2c_cmd_pkg.sv
// Command encodings for the byte-level I2C master, plus TMP102 register
// pointers, configuration bytes and the per-step command tables that drive
// the poller's INIT and READ sequences.
package i2c_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_START     = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_READ_ACK  = 3'd2,
        CMD_READ_NACK = 3'd3,
        CMD_STOP      = 3'd4
    } i2c_cmd_e;

    localparam logic [7:0] TMP102_PTR_TEMP   = 8'h00;
    localparam logic [7:0] TMP102_PTR_CONFIG = 8'h01;
    localparam logic [7:0] TMP102_CFG_MSB    = 8'h60;
    localparam logic [7:0] TMP102_CFG_LSB_NM = 8'hA0;
    localparam logic [7:0] TMP102_CFG_LSB_EM = 8'hB0;

    localparam logic [2:0] INIT_LAST_STEP = 3'd5;
    localparam logic [2:0] READ_LAST_STEP = 3'd7;

    // INIT: START, 4 x WRITE (address, pointer, config MSB, config LSB), STOP
    function automatic i2c_cmd_e init_cmd(input logic [2:0] step);
        case (step)
            3'd0:                     init_cmd = CMD_START;
            3'd1, 3'd2, 3'd3, 3'd4:   init_cmd = CMD_WRITE;
            default:                  init_cmd = CMD_STOP;
        endcase
    endfunction

    // READ: set pointer, repeated START, read two bytes, STOP
    function automatic i2c_cmd_e read_cmd(input logic [2:0] step);
        case (step)
            3'd0, 3'd3:       read_cmd = CMD_START;
            3'd1, 3'd2, 3'd4: read_cmd = CMD_WRITE;
            3'd5:             read_cmd = CMD_READ_ACK;
            3'd6:             read_cmd = CMD_READ_NACK;
            default:          read_cmd = CMD_STOP;
        endcase
    endfunction

endpackage

// File: rtl/tmp102_poller_poll_timer.sv
// Down-counter spacing successive TMP102 reads. Loaded on entry to WAIT and
// decremented only while the poller sits in WAIT.
module poll_timer #(
    parameter logic [31:0] POLL_CYCLES = 32'd12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    logic [31:0] count;

    // Load with POLL_CYCLES-1 so that WAIT lasts exactly POLL_CYCLES cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= POLL_CYCLES - 32'd1;
        end else if (run && (count != '0)) begin
            count <= count - 32'd1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/tmp102_poller.sv
// TMP102 poller: configures the sensor once, then periodically reads the
// temperature register through a byte-level I2C master. Write NACKs abort
// the sequence with a STOP and raise a sticky error flag.
module tmp102_poller
    import i2c_cmd_pkg::*;
#(
    parameter logic [6:0]  I2C_ADR     = 7'b1001000,
    parameter bit          EXTENDED    = 1'b0,
    parameter logic [31:0] POLL_CYCLES = 32'd12500000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [2:0]  cmd_o,
    output logic [7:0]  wdata_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    input  logic        rsp_valid_i,
    input  logic        rsp_nack_i,
    input  logic [7:0]  rdata_i,
    output logic [12:0] temp_o,
    output logic        temp_valid_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    typedef enum logic [2:0] {
        ST_INIT_ISSUE,
        ST_INIT_RSP,
        ST_WAIT,
        ST_RD_ISSUE,
        ST_RD_RSP,
        ST_ABORT_STOP,
        ST_ABORT_RSP
    } state_e;

    state_e     state;
    logic [2:0] step;
    logic       init_done;
    logic [7:0] byte1;
    logic [7:0] byte2;
    logic       write_nack;
    logic       last_step;
    logic       timer_load;
    logic       timer_expired;

    function automatic logic [7:0] init_data(input logic [2:0] s);
        case (s)
            3'd1:    init_data = {I2C_ADR, 1'b0};
            3'd2:    init_data = TMP102_PTR_CONFIG;
            3'd3:    init_data = TMP102_CFG_MSB;
            3'd4:    init_data = EXTENDED ? TMP102_CFG_LSB_EM : TMP102_CFG_LSB_NM;
            default: init_data = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] read_data(input logic [2:0] s);
        case (s)
            3'd1:    read_data = {I2C_ADR, 1'b0};
            3'd2:    read_data = TMP102_PTR_TEMP;
            3'd4:    read_data = {I2C_ADR, 1'b1};
            default: read_data = 8'h00;
        endcase
    endfunction

    // Normal mode is a 12-bit left-justified value; extended mode is 13-bit
    function automatic logic [12:0] to_temp(input logic [7:0] b1, input logic [7:0] b2);
        if (EXTENDED) begin
            to_temp = {b1, b2[7:3]};
        end else begin
            to_temp = {b1[7], b1, b2[7:4]};
        end
    endfunction

    // A NACK only means something as the answer to a WRITE
    assign write_nack = rsp_valid_i && rsp_nack_i && (cmd_o == CMD_WRITE);
    assign last_step  = (state == ST_INIT_RSP) ? (step == INIT_LAST_STEP)
                                               : (step == READ_LAST_STEP);
    assign timer_load = rsp_valid_i &&
                        ((((state == ST_INIT_RSP) || (state == ST_RD_RSP)) && last_step) ||
                         (state == ST_ABORT_RSP));

    poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_poll_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .load    (timer_load),
        .run     (state == ST_WAIT),
        .expired (timer_expired)
    );

    // Capture the two temperature bytes as their read responses arrive
    always_ff @(posedge clk_i) begin
        if ((state == ST_RD_RSP) && rsp_valid_i) begin
            if (step == 3'd5) byte1 <= rdata_i;
            if (step == 3'd6) byte2 <= rdata_i;
        end
    end

    // Sequencer: issue one command, wait for its response, step or abort
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_INIT_ISSUE;
            step         <= 3'd0;
            cmd_valid_o  <= 1'b0;
            cmd_o        <= CMD_STOP;
            wdata_o      <= 8'h00;
            temp_o       <= 13'd0;
            temp_valid_o <= 1'b0;
            err_o        <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            temp_valid_o <= 1'b0;
            // Set is written after clear so a coincident NACK wins
            if (err_clr_i) err_o <= 1'b0;
            if (write_nack && ((state == ST_INIT_RSP) || (state == ST_RD_RSP))) err_o <= 1'b1;

            case (state)
                ST_INIT_ISSUE, ST_RD_ISSUE, ST_ABORT_STOP: begin
                    if (!cmd_valid_o) begin
                        cmd_valid_o <= 1'b1;
                        if (state == ST_INIT_ISSUE) begin
                            cmd_o   <= init_cmd(step);
                            wdata_o <= init_data(step);
                        end else if (state == ST_RD_ISSUE) begin
                            cmd_o   <= read_cmd(step);
                            wdata_o <= read_data(step);
                        end else begin
                            cmd_o   <= CMD_STOP;
                            wdata_o <= 8'h00;
                        end
                    end else if (cmd_ready_i) begin
                        cmd_valid_o <= 1'b0;
                        if (state == ST_INIT_ISSUE)    state <= ST_INIT_RSP;
                        else if (state == ST_RD_ISSUE) state <= ST_RD_RSP;
                        else                           state <= ST_ABORT_RSP;
                    end
                end
                ST_INIT_RSP, ST_RD_RSP: begin
                    if (rsp_valid_i) begin
                        if (write_nack) begin
                            state <= ST_ABORT_STOP;
                        end else if (last_step) begin
                            step  <= 3'd0;
                            state <= ST_WAIT;
                            if (state == ST_INIT_RSP) begin
                                init_done <= 1'b1;
                            end else begin
                                temp_o       <= to_temp(byte1, byte2);
                                temp_valid_o <= 1'b1;
                            end
                        end else begin
                            step  <= step + 3'd1;
                            state <= (state == ST_INIT_RSP) ? ST_INIT_ISSUE : ST_RD_ISSUE;
                        end
                    end
                end
                ST_ABORT_RSP: begin
                    if (rsp_valid_i) begin
                        step  <= 3'd0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timer_expired) begin
                        state <= init_done ? ST_RD_ISSUE : ST_INIT_ISSUE;
                    end
                end
                default: state <= ST_INIT_ISSUE;
            endcase
        end
    end

endmodule
